fetch_pc_gen: RTL and testbench
===============================

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch PC loaded on reset.
REQ-002 clock  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 btb_PCs  output  `N x ADDR  lane PCs presented to BTB lookup (combinational).
REQ-005 btb_target_PCs  input  `N x ADDR  BTB predicted targets, same cycle.
REQ-006 btb_hit  input  `N  BTB hit per lane, same cycle.
REQ-007 fetch_PCs  output  `N x ADDR  lane PCs of the current bundle.
REQ-008 fetch_valid  output  `N  lane valid mask.
REQ-009 fetch_pred_taken  output  `N  one-hot (or zero) marker of the predicted-taken lane.
REQ-010 fetch_pred_target  output  ADDR  predicted target of the marked lane, 0 if none.
REQ-011 fetch_ready  input  1  downstream accepts the whole bundle this cycle.
REQ-012 redirect_valid  input  1  branch stack / retire redirect request.
REQ-013 redirect_PC  input  ADDR  redirect destination.
REQ-014 halt  input  1  stop fetching until next redirect.

Function
REQ-015 States: FETCH, BUBBLE, HALTED; state and fetch_PC registered.
REQ-016 btb_PCs[i] = fetch_PC + 4*i, mod 2^32 wrap; fetch_PCs equals btb_PCs.
REQ-017 first_hit = lowest lane i with btb_hit[i]; none -> no taken prediction.
REQ-018 In FETCH: fetch_valid[i] = 1 for i <= first_hit, all lanes if no hit; BUBBLE/HALTED: fetch_valid = 0.
REQ-019 fetch_pred_taken[first_hit] = 1 only in FETCH with a hit; fetch_pred_target = btb_target_PCs[first_hit] then.
REQ-020 Transfer = state FETCH and fetch_ready; on transfer fetch_PC <= hit ? btb_target_PCs[first_hit] : fetch_PC + 4*`N (wrap).
REQ-021 FETCH without fetch_ready: fetch_PC and all outputs held stable (given stable BTB inputs).
REQ-022 redirect_valid highest priority in any state: fetch_PC <= {redirect_PC[31:2], 2'b00}, state <= BUBBLE, current bundle not transferred regardless of fetch_ready.
REQ-023 BUBBLE -> FETCH unconditionally after one cycle (unless new redirect, which reloads and stays BUBBLE).
REQ-024 halt (no redirect) in FETCH: bundle transferred if fetch_ready this cycle, then state <= HALTED; HALTED holds fetch_PC until redirect_valid.
REQ-025 Simultaneous redirect and halt: redirect wins, halt ignored.
REQ-026 BTB target low bits used as given; no alignment check.

Reset
REQ-027 On reset: fetch_PC <= RESET_PC, state <= FETCH; reset overrides redirect and halt.
REQ-028 Outputs in first post-reset cycle: fetch_PCs = RESET_PC+4i, fetch_valid per BTB inputs (all-ones if no hit).
REQ-029 Reset mid-stall or in HALTED discards pending bundle, no transfer that cycle.

Structure
REQ-030 FETCH_STATE enum belongs in sys_defs.svh; ADDR, `N reused from it.
REQ-031 One sub-module natural: first_hit_sel (lowest-set-bit priority encoder producing index and one-hot).
REQ-032 Single register block for fetch_PC and state; all remaining logic combinational.

Verification (`N=4, RESET_PC=0)
REQ-033 Reset, no hits, fetch_ready=1 for 3 cycles -> fetch_PCs base 0x0, 0x10, 0x20; fetch_valid=4'b1111 each.
REQ-034 fetch_PC=0x40, btb_hit=4'b0110, target[1]=0x200 -> fetch_valid=4'b0011, pred_taken=4'b0010, next base 0x200.
REQ-035 fetch_ready=0 for 3 cycles at 0x80 -> outputs held, fetch_PC stays 0x80; ready=1 -> next base 0x90.
REQ-036 redirect_valid with redirect_PC=0x1003 while fetch_ready=1 -> no transfer, next cycle fetch_valid=0 (BUBBLE), following cycle base 0x1000.
REQ-037 halt at 0x300 with ready=1 -> bundle transferred, then fetch_valid=0 indefinitely; redirect 0x400 -> bubble, then base 0x400.
REQ-038 fetch_PC=0xFFFF_FFF8, no hit, transfer -> next base 0x0000_0008, lanes 2-3 wrap to 0x0, 0x4.

Source files
------------

// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and widths for the fetch PC generator: lane count, address width, FSM states.
package fetch_pc_gen_pkg;

  localparam int N      = 4;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    BUBBLE = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Redirect targets are forced to word alignment; BTB targets are not.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return pc & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/fetch_pc_gen_first_hit_sel.sv
// Lowest-set-bit priority encoder over the per-lane BTB hit vector.
module fetch_pc_gen_first_hit_sel
  import fetch_pc_gen_pkg::*;
(
  input  logic [N-1:0]     hit,
  output logic             any,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    // Scan from the top so the lowest hit lane is written last and wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any    = 1'b1;
        idx    = IDX_W'(i);
        onehot = N'(1) << i;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: presents an N-lane bundle, truncates at the first BTB hit,
// and steers the next fetch PC from BTB, sequential increment, or redirect.
//
// state  | meaning
// FETCH  | bundle presented; advances when fetch_ready
// BUBBLE | one dead cycle after a redirect reload
// HALTED | no fetch until the next redirect
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [N-1:0][ADDR_W-1:0] btb_PCs,
  input  logic [N-1:0][ADDR_W-1:0] btb_target_PCs,
  input  logic [N-1:0]             btb_hit,
  output logic [N-1:0][ADDR_W-1:0] fetch_PCs,
  output logic [N-1:0]             fetch_valid,
  output logic [N-1:0]             fetch_pred_taken,
  output logic [ADDR_W-1:0]        fetch_pred_target,
  input  logic                     fetch_ready,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_PC,
  input  logic                     halt
);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_next;

  logic              hit_any;
  logic [IDX_W-1:0]  hit_idx;
  logic [N-1:0]      hit_onehot;
  logic [ADDR_W-1:0] hit_target;
  logic              in_fetch;

  fetch_pc_gen_first_hit_sel u_first_hit_sel (
    .hit    (btb_hit),
    .any    (hit_any),
    .idx    (hit_idx),
    .onehot (hit_onehot)
  );

  assign hit_target = btb_target_PCs[hit_idx];
  assign in_fetch   = (state == FETCH);

  always_comb begin
    btb_PCs           = '0;
    fetch_PCs         = '0;
    fetch_valid       = '0;
    fetch_pred_taken  = '0;
    fetch_pred_target = '0;
    for (int i = 0; i < N; i++) begin
      btb_PCs[i]     = fetch_pc + ADDR_W'(4 * i);
      fetch_PCs[i]   = fetch_pc + ADDR_W'(4 * i);
      fetch_valid[i] = in_fetch && (!hit_any || (IDX_W'(i) <= hit_idx));
    end
    if (in_fetch && hit_any) begin
      fetch_pred_taken  = hit_onehot;
      fetch_pred_target = hit_target;
    end
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    if (redirect_valid) begin
      state_next    = BUBBLE;
      fetch_pc_next = align_pc(redirect_PC);
    end else begin
      case (state)
        FETCH: begin
          if (fetch_ready) begin
            fetch_pc_next = hit_any ? hit_target : fetch_pc + ADDR_W'(4 * N);
          end
          if (halt) begin
            state_next = HALTED;
          end
        end
        BUBBLE:  state_next = FETCH;
        HALTED:  state_next = HALTED;
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: stimulus queues expected bundles, a negedge monitor checks each transfer.
module tb_fetch_pc_gen;

  logic              clock = 1'b0;
  logic              reset;
  logic [3:0][31:0]  btb_PCs;
  logic [3:0][31:0]  btb_target_PCs;
  logic [3:0]        btb_hit;
  logic [3:0][31:0]  fetch_PCs;
  logic [3:0]        fetch_valid;
  logic [3:0]        fetch_pred_taken;
  logic [31:0]       fetch_pred_target;
  logic              fetch_ready;
  logic              redirect_valid;
  logic [31:0]       redirect_PC;
  logic              halt;

  typedef struct {
    logic [31:0] base;
    logic [3:0]  valid;
    logic [3:0]  taken;
    logic [31:0] target;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_pc_gen #(.RESET_PC(32'h0000_0000)) dut (
    .clock             (clock),
    .reset             (reset),
    .btb_PCs           (btb_PCs),
    .btb_target_PCs    (btb_target_PCs),
    .btb_hit           (btb_hit),
    .fetch_PCs         (fetch_PCs),
    .fetch_valid       (fetch_valid),
    .fetch_pred_taken  (fetch_pred_taken),
    .fetch_pred_target (fetch_pred_target),
    .fetch_ready       (fetch_ready),
    .redirect_valid    (redirect_valid),
    .redirect_PC       (redirect_PC),
    .halt              (halt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] base, input logic [3:0] valid,
                          input logic [3:0] taken, input logic [31:0] target);
    exp_t e;
    e.base = base; e.valid = valid; e.taken = taken; e.target = target;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: a transfer is any FETCH-cycle bundle accepted without redirect or reset.
  always @(negedge clock) begin
    if (!reset && fetch_ready && !redirect_valid && (fetch_valid != 4'b0000)) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_transfer: got base %h expected no transfer", fetch_PCs[0]);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        for (int i = 0; i < 4; i++)
          check($sformatf("bundle_lane%0d_pc", i), fetch_PCs[i], e.base + 32'(4 * i));
        check("bundle_btb_pc0", btb_PCs[0], e.base);
        check("bundle_valid", {28'd0, fetch_valid}, {28'd0, e.valid});
        check("bundle_taken", {28'd0, fetch_pred_taken}, {28'd0, e.taken});
        check("bundle_target", fetch_pred_target, e.target);
      end
    end
  end

  initial begin
    reset = 1'b1; fetch_ready = 1'b0; redirect_valid = 1'b0; redirect_PC = '0;
    halt = 1'b0; btb_hit = '0; btb_target_PCs = '0;
    repeat (2) step();
    reset = 1'b0;

    // Post-reset outputs
    check("reset_pc0", fetch_PCs[0], 32'h0);
    check("reset_pc3", fetch_PCs[3], 32'hC);
    check("reset_valid", {28'd0, fetch_valid}, 32'hF);
    check("reset_taken", {28'd0, fetch_pred_taken}, 32'h0);

    // Sequential fetch
    fetch_ready = 1'b1;
    push_exp(32'h00, 4'hF, 4'h0, 32'h0); step();
    push_exp(32'h10, 4'hF, 4'h0, 32'h0); step();
    push_exp(32'h20, 4'hF, 4'h0, 32'h0); step();
    push_exp(32'h30, 4'hF, 4'h0, 32'h0); step();

    // Taken branch in lane 1 at 0x40
    btb_hit = 4'b0110;
    btb_target_PCs[1] = 32'h200;
    btb_target_PCs[2] = 32'h999;
    push_exp(32'h40, 4'b0011, 4'b0010, 32'h200); step();
    btb_hit = '0;
    fetch_ready = 1'b0;
    check("btb_next_base", fetch_PCs[0], 32'h200);

    // Stall at 0x80
    redirect_valid = 1'b1; redirect_PC = 32'h80; step();
    redirect_valid = 1'b0;
    check("bubble_valid_a", {28'd0, fetch_valid}, 32'h0);
    step();
    for (int k = 0; k < 3; k++) begin
      check("stall_pc", fetch_PCs[0], 32'h80);
      check("stall_valid", {28'd0, fetch_valid}, 32'hF);
      step();
    end
    fetch_ready = 1'b1;
    push_exp(32'h80, 4'hF, 4'h0, 32'h0); step();
    fetch_ready = 1'b0;
    check("post_stall_base", fetch_PCs[0], 32'h90);

    // Redirect beats ready, low bits dropped
    fetch_ready = 1'b1; redirect_valid = 1'b1; redirect_PC = 32'h1003; step();
    redirect_valid = 1'b0;
    check("redirect_bubble_valid", {28'd0, fetch_valid}, 32'h0);
    step();
    push_exp(32'h1000, 4'hF, 4'h0, 32'h0); step();
    fetch_ready = 1'b0;
    check("after_redirect_base", fetch_PCs[0], 32'h1010);

    // Halt at 0x300
    redirect_valid = 1'b1; redirect_PC = 32'h300; step();
    redirect_valid = 1'b0; step();
    halt = 1'b1; fetch_ready = 1'b1;
    push_exp(32'h300, 4'hF, 4'h0, 32'h0); step();
    halt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("halted_valid", {28'd0, fetch_valid}, 32'h0);
      step();
    end
    fetch_ready = 1'b0;
    redirect_valid = 1'b1; redirect_PC = 32'h400; step();
    redirect_valid = 1'b0;
    check("unhalt_bubble_valid", {28'd0, fetch_valid}, 32'h0);
    step();
    check("unhalt_base", fetch_PCs[0], 32'h400);
    check("unhalt_valid", {28'd0, fetch_valid}, 32'hF);

    // Redirect and halt together: halt ignored
    redirect_valid = 1'b1; redirect_PC = 32'h500; halt = 1'b1; step();
    redirect_valid = 1'b0; halt = 1'b0; step();
    check("redir_halt_base", fetch_PCs[0], 32'h500);
    check("redir_halt_valid", {28'd0, fetch_valid}, 32'hF);

    // Address wrap
    redirect_valid = 1'b1; redirect_PC = 32'hFFFF_FFF8; step();
    redirect_valid = 1'b0; step();
    check("wrap_lane2", btb_PCs[2], 32'h0);
    check("wrap_lane3", btb_PCs[3], 32'h4);
    fetch_ready = 1'b1;
    push_exp(32'hFFFF_FFF8, 4'hF, 4'h0, 32'h0); step();
    fetch_ready = 1'b0;
    check("wrap_next_base", fetch_PCs[0], 32'h8);

    // Hit in last lane with unaligned target
    btb_hit = 4'b1000; btb_target_PCs[3] = 32'h2002; fetch_ready = 1'b1;
    push_exp(32'h8, 4'hF, 4'b1000, 32'h2002); step();
    btb_hit = '0; fetch_ready = 1'b0;
    check("unaligned_target_base", fetch_PCs[0], 32'h2002);

    // Reset during stall and over a redirect
    reset = 1'b1; step();
    reset = 1'b0;
    check("reset_stall_base", fetch_PCs[0], 32'h0);
    reset = 1'b1; redirect_valid = 1'b1; redirect_PC = 32'h700; fetch_ready = 1'b1; halt = 1'b1; step();
    reset = 1'b0; redirect_valid = 1'b0; fetch_ready = 1'b0; halt = 1'b0;
    check("reset_over_redirect_base", fetch_PCs[0], 32'h0);
    check("reset_over_redirect_valid", {28'd0, fetch_valid}, 32'hF);

    step();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
